// File: rtl/cmd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmd_arbiter: round-robin arbiter that hands one command at a time to the  |
// | shared cache controller and routes its status back.  Rev 1.0              |
// +--------------------------------------------------------------------------+
module cmd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int KEY_WIDTH = 16,
  parameter int VAL_WIDTH = 32,
  parameter int TIMEOUT   = 255,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [3*NUM_REQ-1:0]           req_op,
  input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key,
  input  logic [VAL_WIDTH*NUM_REQ-1:0]   req_value,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_error,
  output logic [VAL_WIDTH-1:0]           rsp_value,
  output logic                           ctrl_valid,
  input  logic                           ctrl_ready,
  output logic [2:0]                     ctrl_op,
  output logic [KEY_WIDTH-1:0]           ctrl_key,
  output logic [VAL_WIDTH-1:0]           ctrl_value,
  input  logic [1:0]                     ctrl_status,
  input  logic [VAL_WIDTH-1:0]           ctrl_rd_value,
  output logic                           busy,
  output logic [IDW-1:0]                 grant_id
);

  localparam int             CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  C_CNT_MAX   = CW'(TIMEOUT - 1);
  localparam logic [2:0]     C_OP_NOOP   = 3'd0;
  localparam logic [IDW-1:0] C_PTR_RESET = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [2:0]           op_q, op_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [VAL_WIDTH-1:0] val_q, val_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [VAL_WIDTH-1:0] rsp_val_q, rsp_val_d;

  logic                 found;
  logic [IDW-1:0]       win_id;
  logic [2:0]           acc_op;
  int                   idx;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        win_id = IDW'(idx);
      end
    end
  end

  assign acc_op = req_op[int'(win_id)*3 +: 3];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    op_d      = op_q;
    key_d     = key_q;
    val_d     = val_q;
    cnt_d     = cnt_q;
    rsp_err_d = rsp_err_q;
    rsp_val_d = rsp_val_q;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          op_d      = acc_op;
          key_d     = req_key[int'(win_id)*KEY_WIDTH +: KEY_WIDTH];
          val_d     = req_value[int'(win_id)*VAL_WIDTH +: VAL_WIDTH];
          grant_d   = win_id;
          ptr_d     = win_id;
          rsp_val_d = '0;
          // NOOP and illegal opcodes are answered locally; bit 2 marks illegal.
          if (acc_op != C_OP_NOOP && !acc_op[2]) begin
            state_d = ST_ISSUE;
          end else begin
            rsp_err_d = acc_op[2];
            state_d   = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        if (ctrl_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (ctrl_status[0]) begin
          rsp_err_d = 1'b1;
          rsp_val_d = '0;
          state_d   = ST_RESP;
        end else if (ctrl_status[1]) begin
          rsp_err_d = 1'b0;
          rsp_val_d = ctrl_rd_value;
          state_d   = ST_RESP;
        end else if (cnt_q == C_CNT_MAX) begin
          rsp_err_d = 1'b1;
          rsp_val_d = '0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= C_PTR_RESET;
      grant_q   <= '0;
      op_q      <= C_OP_NOOP;
      key_q     <= '0;
      val_q     <= '0;
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
      rsp_val_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      op_q      <= op_d;
      key_q     <= key_d;
      val_q     <= val_d;
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
      rsp_val_q <= rsp_val_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE && found) ? (NUM_REQ'(1) << win_id) : '0;
  assign rsp_valid  = (state_q == ST_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
  assign rsp_error  = (state_q == ST_RESP) & rsp_err_q;
  assign rsp_value  = (state_q == ST_RESP) ? rsp_val_q : '0;
  assign ctrl_valid = (state_q == ST_ISSUE);
  assign ctrl_op    = op_q;
  assign ctrl_key   = key_q;
  assign ctrl_value = val_q;
  assign busy       = (state_q != ST_IDLE);
  assign grant_id   = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_arbiter.sv
`default_nettype none
// Directed vector bench for cmd_arbiter: cycle table plus multi-cycle sequences.
module tb_cmd_arbiter;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [63:0] req_key;
  logic [127:0] req_value;
  logic [3:0]  rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_value;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [2:0]  ctrl_op;
  logic [15:0] ctrl_key;
  logic [31:0] ctrl_value;
  logic [1:0]  ctrl_status;
  logic [31:0] ctrl_rd_value;
  logic        busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmd_arbiter #(.NUM_REQ(4), .KEY_WIDTH(16), .VAL_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_value(rsp_value),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_op(ctrl_op),
    .ctrl_key(ctrl_key), .ctrl_value(ctrl_value), .ctrl_status(ctrl_status),
    .ctrl_rd_value(ctrl_rd_value), .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    logic [3:0]  rv;
    logic [11:0] ops;
    logic        crdy;
    logic [1:0]  cst;
    logic [31:0] rdv;
    logic [3:0]  e_rr;
    logic        e_cv;
    logic [2:0]  e_cop;
    logic [15:0] e_key;
    logic [3:0]  e_rsv;
    logic        e_rse;
    logic [31:0] e_rsval;
    logic        e_busy;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic [3:0] rv, input logic [11:0] ops, input logic crdy,
                              input logic [1:0] cst, input logic [31:0] rdv, input logic [3:0] e_rr,
                              input logic e_cv, input logic [2:0] e_cop, input logic [15:0] e_key,
                              input logic [3:0] e_rsv, input logic e_rse, input logic [31:0] e_rsval,
                              input logic e_busy, input logic [1:0] e_gid);
    vec_t v;
    v.rv = rv; v.ops = ops; v.crdy = crdy; v.cst = cst; v.rdv = rdv;
    v.e_rr = e_rr; v.e_cv = e_cv; v.e_cop = e_cop; v.e_key = e_key;
    v.e_rsv = e_rsv; v.e_rse = e_rse; v.e_rsval = e_rsval; v.e_busy = e_busy; v.e_gid = e_gid;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [11:0] rd1, up;
    int n;
    logic got;
    rd1 = {3'd0, 3'd0, 3'd0, 3'd1};
    up  = {3'd2, 3'd2, 3'd2, 3'd2};
    //            rv     ops  rdy cst    rdv           rr     cv cop  key       rsv    rse val           bsy gid
    vecs[0]  = mk(4'h1, rd1, 1, 2'b00, 32'h0,        4'h1, 0, 3'd0, 16'h0000, 4'h0, 0, 32'h0,        0, 2'd0);
    vecs[1]  = mk(4'h0, rd1, 1, 2'b00, 32'h0,        4'h0, 1, 3'd1, 16'h00AB, 4'h0, 0, 32'h0,        1, 2'd0);
    vecs[2]  = mk(4'h0, rd1, 1, 2'b10, 32'hDEADBEEF, 4'h0, 0, 3'd1, 16'h00AB, 4'h0, 0, 32'h0,        1, 2'd0);
    vecs[3]  = mk(4'h0, rd1, 1, 2'b00, 32'h0,        4'h0, 0, 3'd1, 16'h00AB, 4'h1, 0, 32'hDEADBEEF, 1, 2'd0);
    vecs[4]  = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h2, 0, 3'd1, 16'h00AB, 4'h0, 0, 32'h0,        0, 2'd0);
    vecs[5]  = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h0, 1, 3'd2, 16'h1001, 4'h0, 0, 32'h0,        1, 2'd1);
    vecs[6]  = mk(4'hF, up,  1, 2'b10, 32'h11,       4'h0, 0, 3'd2, 16'h1001, 4'h0, 0, 32'h0,        1, 2'd1);
    vecs[7]  = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h0, 0, 3'd2, 16'h1001, 4'h2, 0, 32'h11,       1, 2'd1);
    vecs[8]  = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h4, 0, 3'd2, 16'h1001, 4'h0, 0, 32'h0,        0, 2'd1);
    vecs[9]  = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h0, 1, 3'd2, 16'h1002, 4'h0, 0, 32'h0,        1, 2'd2);
    vecs[10] = mk(4'hF, up,  1, 2'b10, 32'h22,       4'h0, 0, 3'd2, 16'h1002, 4'h0, 0, 32'h0,        1, 2'd2);
    vecs[11] = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h0, 0, 3'd2, 16'h1002, 4'h4, 0, 32'h22,       1, 2'd2);
    vecs[12] = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h8, 0, 3'd2, 16'h1002, 4'h0, 0, 32'h0,        0, 2'd2);
    vecs[13] = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h0, 1, 3'd2, 16'h1003, 4'h0, 0, 32'h0,        1, 2'd3);
    vecs[14] = mk(4'hF, up,  1, 2'b10, 32'h33,       4'h0, 0, 3'd2, 16'h1003, 4'h0, 0, 32'h0,        1, 2'd3);
    vecs[15] = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h0, 0, 3'd2, 16'h1003, 4'h8, 0, 32'h33,       1, 2'd3);
    vecs[16] = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h1, 0, 3'd2, 16'h1003, 4'h0, 0, 32'h0,        0, 2'd3);
    vecs[17] = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h0, 1, 3'd2, 16'h00AB, 4'h0, 0, 32'h0,        1, 2'd0);
    vecs[18] = mk(4'hF, up,  1, 2'b10, 32'h44,       4'h0, 0, 3'd2, 16'h00AB, 4'h0, 0, 32'h0,        1, 2'd0);
    vecs[19] = mk(4'hF, up,  1, 2'b00, 32'h0,        4'h0, 0, 3'd2, 16'h00AB, 4'h1, 0, 32'h44,       1, 2'd0);

    rst = 1'b1; req_valid = '0; req_op = '0; ctrl_ready = 1'b0; ctrl_status = '0; ctrl_rd_value = '0;
    req_key   = {16'h1003, 16'h1002, 16'h1001, 16'h00AB};
    req_value = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {req_ready, rsp_valid, rsp_error, rsp_value, ctrl_valid, ctrl_op, ctrl_key, busy, grant_id}, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      req_valid = vecs[i].rv; req_op = vecs[i].ops; ctrl_ready = vecs[i].crdy;
      ctrl_status = vecs[i].cst; ctrl_rd_value = vecs[i].rdv;
      #1;
      chk($sformatf("v%0d_req_ready", i), req_ready, vecs[i].e_rr);
      chk($sformatf("v%0d_ctrl", i), {ctrl_valid, ctrl_op, ctrl_key}, {vecs[i].e_cv, vecs[i].e_cop, vecs[i].e_key});
      chk($sformatf("v%0d_rsp", i), {rsp_valid, rsp_error, rsp_value}, {vecs[i].e_rsv, vecs[i].e_rse, vecs[i].e_rsval});
      chk($sformatf("v%0d_busy_gid", i), {busy, grant_id}, {vecs[i].e_busy, vecs[i].e_gid});
      @(negedge clk);
    end

    // ctrl_ready held low in ISSUE; status pins toggled to prove they are ignored there
    req_valid = 4'h2; req_op = {3'd0, 3'd0, 3'd1, 3'd0}; ctrl_ready = 0; ctrl_status = 0;
    #1; chk("stall_accept", req_ready, 4'h2);
    @(negedge clk);
    req_valid = 0; ctrl_status = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1; chk($sformatf("stall_hold%0d", i), {ctrl_valid, ctrl_op, ctrl_key, ctrl_value, busy}, {1'b1, 3'd1, 16'h1001, 32'hA0000001, 1'b1});
      @(negedge clk);
    end
    ctrl_ready = 1;
    #1; chk("stall_release", ctrl_valid, 1'b1);
    @(negedge clk);
    ctrl_ready = 0; ctrl_status = 2'b10; ctrl_rd_value = 32'hCAFE0001;
    #1; chk("stall_wait", {ctrl_valid, rsp_valid}, 5'b0);
    @(negedge clk);
    ctrl_status = 0;
    #1; chk("stall_rsp", {rsp_valid, rsp_error, rsp_value}, {4'h2, 1'b0, 32'hCAFE0001});
    @(negedge clk);

    // DELETE with no status: forced error after TO wait cycles
    req_valid = 4'h4; req_op = {3'd0, 3'd3, 3'd0, 3'd0};
    #1; chk("to_accept", req_ready, 4'h4);
    @(negedge clk);
    req_valid = 0; ctrl_ready = 1;
    #1; chk("to_issue", {ctrl_valid, ctrl_op, ctrl_key}, {1'b1, 3'd3, 16'h1002});
    @(negedge clk);
    ctrl_ready = 0;
    n = 0; got = 0;
    for (int i = 0; i < TO + 10 && !got; i++) begin
      #1;
      if (rsp_valid != 0) got = 1;
      else begin
        n++;
        @(negedge clk);
      end
    end
    chk("to_seen", got, 1'b1);
    chk("to_cycles", n, TO);
    chk("to_rsp", {rsp_valid, rsp_error, rsp_value}, {4'h4, 1'b1, 32'h0});
    @(negedge clk);
    req_valid = 4'hF; req_op = '0;
    #1; chk("to_next_grant", req_ready, 4'h8);
    @(negedge clk);
    req_valid = 0;
    #1; chk("to_next_rsp", {rsp_valid, rsp_error, ctrl_valid}, {4'h8, 1'b0, 1'b0});
    @(negedge clk);

    // illegal op then NOOP from requester 2, both answered locally
    req_valid = 4'h4; req_op = {3'd0, 3'd5, 3'd0, 3'd0};
    #1; chk("ill_accept", req_ready, 4'h4);
    @(negedge clk);
    req_valid = 0;
    #1; chk("ill_rsp", {rsp_valid, rsp_error, rsp_value, ctrl_valid}, {4'h4, 1'b1, 32'h0, 1'b0});
    @(negedge clk);
    req_valid = 4'h4; req_op = '0;
    #1; chk("noop_accept", {req_ready, ctrl_valid}, {4'h4, 1'b0});
    @(negedge clk);
    req_valid = 0;
    #1; chk("noop_rsp", {rsp_valid, rsp_error, rsp_value, ctrl_valid}, {4'h4, 1'b0, 32'h0, 1'b0});
    @(negedge clk);

    // done and error together: error wins
    req_valid = 4'h1; req_op = {3'd0, 3'd0, 3'd0, 3'd1};
    #1; chk("both_accept", req_ready, 4'h1);
    @(negedge clk);
    req_valid = 0; ctrl_ready = 1;
    #1; chk("both_issue", ctrl_valid, 1'b1);
    @(negedge clk);
    ctrl_ready = 0; ctrl_status = 2'b11; ctrl_rd_value = 32'h12345678;
    @(negedge clk);
    ctrl_status = 0;
    #1; chk("both_rsp", {rsp_valid, rsp_error, rsp_value}, {4'h1, 1'b1, 32'h0});
    @(negedge clk);

    // asynchronous reset in WAIT
    req_valid = 4'h2; req_op = {3'd0, 3'd0, 3'd1, 3'd0};
    #1; chk("rst_accept", req_ready, 4'h2);
    @(negedge clk);
    req_valid = 0; ctrl_ready = 1;
    @(negedge clk);
    ctrl_ready = 0;
    #1; chk("rst_in_wait", {busy, ctrl_valid}, 2'b10);
    @(negedge clk);
    rst = 1;
    #1; chk("rst_async", {req_ready, rsp_valid, rsp_error, rsp_value, ctrl_valid, ctrl_op, ctrl_key, busy, grant_id}, '0);
    @(negedge clk);
    rst = 0; ctrl_status = 2'b10;
    #1; chk("rst_no_rsp", {rsp_valid, busy}, 5'b0);
    @(negedge clk);
    ctrl_status = 0; req_valid = 4'hF; req_op = '0;
    #1; chk("rst_ptr", req_ready, 4'h1);
    @(negedge clk);
    req_valid = 0;
    #1; chk("rst_ptr_rsp", rsp_valid, 4'h1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
